// File: rtl/fp_divsqrt_pool_pkg.sv
// Shared FP ops package for the iterative div/sqrt pool.
// Holds the issue width that sets the default channel count, the FFlags
// width, and the per-channel state encoding used by the pool and channels.
package fp_divsqrt_pool_pkg;

    localparam int FP_DIVSQRT_ISSUE_WIDTH = 2;
    localparam int FFLAGS_W               = 5;

    typedef enum logic [1:0] {
        CH_FREE     = 2'd0,
        CH_RESERVED = 2'd1,
        CH_BUSY     = 2'd2,
        CH_DONE     = 2'd3
    } ch_state_t;

endpackage

// File: rtl/fp_divsqrt_channel.sv
// One div/sqrt channel: lifecycle FSM, owner active-list pointer, result
// buffer and the wrap-around flush range compare.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   grant, grant_ptr         allocator picked this channel; owner pointer
//   req_sel, rel_sel         req/release addressed here with stall low
//   core_done/result/flags   completion from the attached core
//   flush, flush_head/tail   selective flush range
//   state                    registered channel state
//   start, kill              one-cycle start / abort to the core
//   result, flags            latched core result and FFlags
module fp_divsqrt_channel
    import fp_divsqrt_pool_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int AL_W   = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                grant,
    input  logic [AL_W-1:0]     grant_ptr,
    input  logic                req_sel,
    input  logic                rel_sel,
    input  logic                core_done,
    input  logic [DATA_W-1:0]   core_result,
    input  logic [FFLAGS_W-1:0] core_flags,
    input  logic                flush,
    input  logic [AL_W-1:0]     flush_head,
    input  logic [AL_W-1:0]     flush_tail,
    output ch_state_t           state,
    output logic                start,
    output logic                kill,
    output logic [DATA_W-1:0]   result,
    output logic [FFLAGS_W-1:0] flags
);

    logic [AL_W-1:0] ptr;
    logic [AL_W-1:0] ptr_off;
    logic [AL_W-1:0] range_len;
    logic            hit;
    logic            latch;
    logic            rel_ok;

    // Distances from the flush head are taken modulo 2^AL_W so the range
    // may wrap past the end of the active list.
    always_comb begin
        ptr_off   = ptr - flush_head;
        range_len = flush_tail - flush_head;
        hit       = flush && (state != CH_FREE) && (ptr_off <= range_len);
        start     = req_sel && (state == CH_RESERVED) && !hit;
        kill      = hit && (state == CH_BUSY);
        latch     = core_done && (state == CH_BUSY) && !hit;
        rel_ok    = rel_sel && (state == CH_DONE) && !hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= CH_FREE;
            ptr    <= '0;
            result <= '0;
            flags  <= '0;
        end else begin
            if (hit) begin
                state <= CH_FREE;
            end else begin
                case (state)
                    CH_FREE: begin
                        if (grant) begin
                            state <= CH_RESERVED;
                            ptr   <= grant_ptr;
                        end
                    end
                    CH_RESERVED: if (start)  state <= CH_BUSY;
                    CH_BUSY:     if (latch)  state <= CH_DONE;
                    CH_DONE:     if (rel_ok) state <= CH_FREE;
                    default:                 state <= CH_FREE;
                endcase
            end
            if (latch) begin
                result <= core_result;
                flags  <= core_flags;
            end
        end
    end

endmodule

// File: rtl/fp_divsqrt_pool.sv
// Pool of NUM_CH iterative div/sqrt channels: allocator, request/release
// decode and output muxing. Each channel drives one external core.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   acquire/acquirePtr               reserve a channel for an AL entry
//   acquireGrant/acquireCh           same-cycle grant, lowest free channel
//   req/reqCh/dataInA/dataInB/isDivide/rm   start an operation
//   releaseReq/releaseCh             result consumed ("release" is a
//                                    reserved word, hence releaseReq)
//   stall                            holds off req and release acceptance
//   flush/flushHeadPtr/flushTailPtr  selective flush of an AL range
//   coreStart/coreKill/coreA/coreB/coreIsDiv/coreRm   to the cores
//   coreDone/coreResult/coreFlags    from the cores
//   dataOut/fflagsOut                latched per-channel results
//   finished/busy/reserved/free      per-channel status
module fp_divsqrt_pool
    import fp_divsqrt_pool_pkg::*;
#(
    parameter int NUM_CH = FP_DIVSQRT_ISSUE_WIDTH,
    parameter int DATA_W = 64,
    parameter int AL_W   = 6,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       acquire,
    input  logic [AL_W-1:0]            acquirePtr,
    output logic                       acquireGrant,
    output logic [CH_W-1:0]            acquireCh,
    input  logic                       req,
    input  logic [CH_W-1:0]            reqCh,
    input  logic [DATA_W-1:0]          dataInA,
    input  logic [DATA_W-1:0]          dataInB,
    input  logic                       isDivide,
    input  logic [2:0]                 rm,
    input  logic                       releaseReq,
    input  logic [CH_W-1:0]            releaseCh,
    input  logic                       stall,
    input  logic                       flush,
    input  logic [AL_W-1:0]            flushHeadPtr,
    input  logic [AL_W-1:0]            flushTailPtr,
    output logic [NUM_CH-1:0]          coreStart,
    output logic [NUM_CH-1:0]          coreKill,
    output logic [DATA_W-1:0]          coreA,
    output logic [DATA_W-1:0]          coreB,
    output logic                       coreIsDiv,
    output logic [2:0]                 coreRm,
    input  logic [NUM_CH-1:0]          coreDone,
    input  logic [NUM_CH*DATA_W-1:0]   coreResult,
    input  logic [NUM_CH*FFLAGS_W-1:0] coreFlags,
    output logic [NUM_CH*DATA_W-1:0]   dataOut,
    output logic [NUM_CH*FFLAGS_W-1:0] fflagsOut,
    output logic [NUM_CH-1:0]          finished,
    output logic [NUM_CH-1:0]          busy,
    output logic [NUM_CH-1:0]          reserved,
    output logic                       free
);

    ch_state_t          ch_state [NUM_CH];
    logic [NUM_CH-1:0]  is_free;
    logic [NUM_CH-1:0]  grant_vec;
    logic               any_free;

    // Lowest-index free channel wins; scanning downward lets the lowest
    // index overwrite any higher candidate.
    always_comb begin
        any_free  = 1'b0;
        acquireCh = '0;
        grant_vec = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (is_free[i]) begin
                any_free  = 1'b1;
                acquireCh = CH_W'(i);
            end
        end
        acquireGrant = acquire && any_free;
        for (int i = 0; i < NUM_CH; i++) begin
            grant_vec[i] = acquireGrant && (acquireCh == CH_W'(i));
        end
    end

    assign coreA     = dataInA;
    assign coreB     = dataInB;
    assign coreIsDiv = isDivide;
    assign coreRm    = rm;
    assign free      = |is_free;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic req_sel;
        logic rel_sel;

        assign req_sel = req && !stall && (reqCh == CH_W'(g));
        assign rel_sel = releaseReq && !stall && (releaseCh == CH_W'(g));

        fp_divsqrt_channel #(
            .DATA_W (DATA_W),
            .AL_W   (AL_W)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .grant       (grant_vec[g]),
            .grant_ptr   (acquirePtr),
            .req_sel     (req_sel),
            .rel_sel     (rel_sel),
            .core_done   (coreDone[g]),
            .core_result (coreResult[g*DATA_W +: DATA_W]),
            .core_flags  (coreFlags[g*FFLAGS_W +: FFLAGS_W]),
            .flush       (flush),
            .flush_head  (flushHeadPtr),
            .flush_tail  (flushTailPtr),
            .state       (ch_state[g]),
            .start       (coreStart[g]),
            .kill        (coreKill[g]),
            .result      (dataOut[g*DATA_W +: DATA_W]),
            .flags       (fflagsOut[g*FFLAGS_W +: FFLAGS_W])
        );

        assign is_free[g]  = (ch_state[g] == CH_FREE);
        assign finished[g] = (ch_state[g] == CH_DONE);
        assign busy[g]     = (ch_state[g] == CH_BUSY);
        assign reserved[g] = (ch_state[g] == CH_RESERVED);
    end

endmodule

// File: doc/fp_divsqrt_pool.md
FP_DIVSQRT_POOL -- requirements
Module: fp_divsqrt_pool

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning the number of independent iterative div/sqrt channels (1..8).
REQ-002 SHALL have parameter DATA_W, default 64, meaning the operand and result width.
REQ-003 SHALL have parameter AL_W, default 6, meaning the active-list pointer width.
REQ-004 SHALL have ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- acquire, in, 1, reserve a channel at issue.
- acquirePtr, in, AL_W, owner active-list index.
- acquireGrant, out, 1, reservation accepted this cycle.
- acquireCh, out, $clog2(NUM_CH), channel granted.
- req, in, 1, start operation.
- reqCh, in, $clog2(NUM_CH), target channel.
- dataInA, in, DATA_W, operand A.
- dataInB, in, DATA_W, operand B.
- isDivide, in, 1, 1 = div, 0 = sqrt.
- rm, in, 3, rounding mode.
- release, in, 1, result consumed.
- releaseCh, in, $clog2(NUM_CH), channel released.
- stall, in, 1, freeze req/release acceptance.
- flush, in, 1, selective flush.
- flushHeadPtr, in, AL_W, flush range start.
- flushTailPtr, in, AL_W, flush range end.
- coreStart, out, NUM_CH, one-cycle start to each core.
- coreKill, out, NUM_CH, abort to each core.
- coreA, out, DATA_W, operand A to cores.
- coreB, out, DATA_W, operand B to cores.
- coreIsDiv, out, 1, op to cores.
- coreRm, out, 3, rounding mode to cores.
- coreDone, in, NUM_CH, core result valid pulse.
- coreResult, in, NUM_CH*DATA_W, core results.
- coreFlags, in, NUM_CH*5, core FFlags.
- dataOut, out, NUM_CH*DATA_W, latched results.
- fflagsOut, out, NUM_CH*5, latched flags.
- finished, out, NUM_CH, result held.
- busy, out, NUM_CH, computing.
- reserved, out, NUM_CH, reserved and not started.
- free, out, 1, at least one channel FREE.

Function
REQ-005 Each channel SHALL run FSM FREE->RESERVED (grant)->BUSY (req accepted)->DONE (coreDone)->FREE (release accepted).
REQ-006 Acquire SHALL grant the lowest-index FREE channel in the same cycle (combinational acquireGrant/acquireCh); the state change and acquirePtr capture SHALL occur at the next edge; no free channel -> acquireGrant=0, no state change.
REQ-007 Req SHALL be accepted only if !stall and channel reqCh is RESERVED; coreStart[reqCh] SHALL pulse in that cycle with coreA/B/IsDiv/Rm driven from the inputs; req to a non-RESERVED channel SHALL be ignored.
REQ-008 In BUSY, coreDone SHALL latch coreResult/coreFlags into the channel buffer and set DONE next cycle; stall SHALL NOT block latching.
REQ-009 Release SHALL be accepted only if !stall and channel is DONE; otherwise it SHALL be ignored.
REQ-010 Flush SHALL kill every non-FREE channel whose stored ptr p satisfies (p - flushHeadPtr) mod 2^AL_W <= (flushTailPtr - flushHeadPtr) mod 2^AL_W; a killed BUSY channel SHALL pulse coreKill; killed channels SHALL be FREE next cycle.
REQ-011 Flush SHALL take priority over acquire, req, coreDone and release on the same channel in the same cycle; a channel granted in the flush cycle SHALL NOT be killed by that flush.
REQ-012 Release and acquire in the same cycle SHALL NOT grant the releasing channel; it becomes grantable next cycle.
REQ-013 Outputs finished/busy/reserved SHALL be decoded from registered state only; free SHALL be the OR of the FREE states.

Reset
REQ-014 Asynchronous rst SHALL force all channels FREE and clear buffers; outputs SHALL be free=1, finished/busy/reserved/coreStart/coreKill=0, and dataOut/fflagsOut=0.
REQ-015 Reset mid-operation SHALL NOT pulse coreKill; the cores are reset by the same rst.

Structure
REQ-016 The channel-state enum and FFlags width SHALL be placed in the shared FP ops package, with NUM_CH defaulting from FP_DIVSQRT_ISSUE_WIDTH.
REQ-017 One sub-module, fp_divsqrt_channel (FSM, ptr, result buffer, flush compare), SHALL be instantiated NUM_CH times; fp_divsqrt_pool SHALL contain the allocator and muxes.

Verification
REQ-018 The bench SHALL cover the following scenarios:
- Reset, then acquire with ptr=5 -> grant ch0; req A=0x4000..(2.0), B=0x3FF0..(1.0), div -> coreStart[0]; coreDone -> finished[0]=1 with dataOut held; release -> free.
- With NUM_CH=2, three back-to-back acquires -> grants ch0 and ch1, third acquireGrant=0 while free=0.
- Flush with head=62, tail=1, channels holding ptrs 63 and 3 -> only the ptr-63 channel is killed (wrap-around), with coreKill pulsed if BUSY.
- Stall=1 with coreDone on a BUSY channel -> result latched; release ignored until stall=0.
- Flush coinciding with coreDone on the same channel -> channel FREE, finished stays 0.
- Async rst asserted mid-BUSY -> immediate FREE, no coreKill.
